// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

    localparam int unsigned N_LED = 4;

    // Button roles within the 4-bit button bank
    localparam logic [1:0] BTN_NEXT  = 2'd0;
    localparam logic [1:0] BTN_PAUSE = 2'd1;
    localparam logic [1:0] BTN_SPEED = 2'd2;
    localparam logic [1:0] BTN_CLR   = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT_L = 3'd1,
        SHIFT_R = 3'd2,
        BOUNCE  = 3'd3,
        BLINK   = 3'd4
    } mode_e;

    // Pattern loaded when a mode is entered
    localparam logic [N_LED-1:0] PAT_IDLE    = 4'b0000;
    localparam logic [N_LED-1:0] PAT_SHIFT_L = 4'b0001;
    localparam logic [N_LED-1:0] PAT_SHIFT_R = 4'b1000;
    localparam logic [N_LED-1:0] PAT_BOUNCE  = 4'b0001;
    localparam logic [N_LED-1:0] PAT_BLINK   = 4'b1111;

    // Mode order for the "next" button, wrapping BLINK back to IDLE
    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            IDLE:    n = SHIFT_L;
            SHIFT_L: n = SHIFT_R;
            SHIFT_R: n = BOUNCE;
            BOUNCE:  n = BLINK;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // Start pattern for a given mode
    function automatic logic [N_LED-1:0] start_pattern(input mode_e m);
        logic [N_LED-1:0] p;
        case (m)
            SHIFT_L: p = PAT_SHIFT_L;
            SHIFT_R: p = PAT_SHIFT_R;
            BOUNCE:  p = PAT_BOUNCE;
            BLINK:   p = PAT_BLINK;
            default: p = PAT_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer, stability debouncer, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Bring the raw asynchronous pin into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES straight cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Single-cycle pulse on the debounced 0->1 transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Button-driven LED pattern sequencer: debounced commands, mode FSM, tick timer.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_LED-1:0] btn,
    output logic [N_LED-1:0] led,
    output logic [2:0]       mode,
    output logic             running,
    output logic             fast
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(TICK_DIV / 4 - 1);
    localparam logic [N_LED-1:0] LED_TOP   = {1'b1, {(N_LED - 1){1'b0}}};
    localparam logic [N_LED-1:0] LED_BOT   = N_LED'(1);

    logic [N_LED-1:0] w_press;
    logic [CNT_W-1:0] w_cnt_last;
    logic             w_tick;
    mode_e            w_mode_nxt;
    logic [N_LED-1:0] w_led_step;
    logic             w_dir_step;

    mode_e            r_mode;
    logic [N_LED-1:0] r_led;
    logic             r_running;
    logic             r_fast;
    logic             r_dir_up;
    logic [CNT_W-1:0] r_cnt;

    // One debouncer per button
    for (genvar gi = 0; gi < N_LED; gi++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (btn[gi]),
            .o_press(w_press[gi])
        );
    end

    assign w_cnt_last = r_fast ? LAST_FAST : LAST_SLOW;
    assign w_tick     = r_running && (r_mode != IDLE) && (r_cnt == w_cnt_last);
    assign w_mode_nxt = next_mode(r_mode);

    // Pattern one step ahead of the current one for the active mode
    always_comb begin
        w_led_step = r_led;
        w_dir_step = r_dir_up;
        case (r_mode)
            SHIFT_L: w_led_step = {r_led[N_LED-2:0], r_led[N_LED-1]};
            SHIFT_R: w_led_step = {r_led[0], r_led[N_LED-1:1]};
            BOUNCE: begin
                if (r_dir_up) begin
                    if (r_led == LED_TOP) begin
                        w_led_step = r_led >> 1;
                        w_dir_step = 1'b0;
                    end else begin
                        w_led_step = r_led << 1;
                    end
                end else begin
                    if (r_led == LED_BOT) begin
                        w_led_step = r_led << 1;
                        w_dir_step = 1'b1;
                    end else begin
                        w_led_step = r_led >> 1;
                    end
                end
            end
            BLINK:   w_led_step = ~r_led;
            default: w_led_step = PAT_IDLE;
        endcase
    end

    // Mode FSM, command handling, tick counter and pattern register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= IDLE;
            r_led     <= PAT_IDLE;
            r_running <= 1'b1;
            r_fast    <= 1'b0;
            r_dir_up  <= 1'b1;
            r_cnt     <= '0;
        end else if (w_press[BTN_CLR]) begin
            r_mode    <= IDLE;
            r_led     <= PAT_IDLE;
            r_running <= 1'b1;
            r_fast    <= 1'b0;
            r_dir_up  <= 1'b1;
            r_cnt     <= '0;
        end else begin
            if (w_press[BTN_PAUSE]) begin
                r_running <= ~r_running;
            end
            if (w_press[BTN_SPEED]) begin
                r_fast <= ~r_fast;
            end
            if (w_press[BTN_NEXT]) begin
                // A mode change discards any tick landing in the same cycle
                r_mode   <= w_mode_nxt;
                r_led    <= start_pattern(w_mode_nxt);
                r_dir_up <= 1'b1;
                r_cnt    <= '0;
            end else begin
                if (w_press[BTN_SPEED]) begin
                    r_cnt <= '0;
                end else if (w_tick) begin
                    r_cnt <= '0;
                end else if (r_running && (r_mode != IDLE)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_tick) begin
                    r_led    <= w_led_step;
                    r_dir_up <= w_dir_step;
                end
            end
        end
    end

    assign led     = r_led;
    assign mode    = r_mode;
    assign running = r_running;
    assign fast    = r_fast;

endmodule
